// File: rtl/tester_intr_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tester_intr_axil_slave
//  Brief    : AXI4-Lite interrupt controller. Latches up to C_NUM_OF_INTR
//             sources into ISR and drives one level irq gated by GIER/IER.
//             Map: 0 GIER, 1 IER, 2 ISR, 3 IAR (W1C), 4 IPR, 5-7 reserved.
//  Revision : 1.0 - initial release
// ============================================================================
module tester_intr_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH  = 32,
  parameter int          C_S_AXI_ADDR_WIDTH  = 5,
  parameter int          C_NUM_OF_INTR       = 1,
  parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFFFFFF,
  parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFFFFFF,
  parameter logic        C_IRQ_ACTIVE_STATE  = 1'b1
) (
  input  logic                            S_AXI_INTR_ACLK,
  input  logic                            S_AXI_INTR_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_INTR_AWADDR,
  input  logic [2:0]                      S_AXI_INTR_AWPROT,
  input  logic                            S_AXI_INTR_AWVALID,
  output logic                            S_AXI_INTR_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_INTR_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_INTR_WSTRB,
  input  logic                            S_AXI_INTR_WVALID,
  output logic                            S_AXI_INTR_WREADY,
  output logic [1:0]                      S_AXI_INTR_BRESP,
  output logic                            S_AXI_INTR_BVALID,
  input  logic                            S_AXI_INTR_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_INTR_ARADDR,
  input  logic [2:0]                      S_AXI_INTR_ARPROT,
  input  logic                            S_AXI_INTR_ARVALID,
  output logic                            S_AXI_INTR_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_INTR_RDATA,
  output logic [1:0]                      S_AXI_INTR_RRESP,
  output logic                            S_AXI_INTR_RVALID,
  input  logic                            S_AXI_INTR_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  output logic                            irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [DW-1:0] c_intr_mask =
    (C_NUM_OF_INTR >= DW) ? {DW{1'b1}} : DW'((64'd1 << C_NUM_OF_INTR) - 64'd1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;
  logic    w_wr_hs, w_rd_hs;

  logic                     r_gier;
  logic [DW-1:0]            r_ier, r_isr, r_rdata;
  logic [C_NUM_OF_INTR-1:0] r_prev;
  logic                     r_irq;

  logic [DW-1:0] w_wmask, w_clr, w_set, w_rd_mux;
  logic [2:0]    w_wsel, w_rsel;
  logic          w_unused_ok;

  assign w_wsel = S_AXI_INTR_AWADDR[4:2];
  assign w_rsel = S_AXI_INTR_ARADDR[4:2];

  // Protection bits and byte-offset address bits carry no meaning here.
  assign w_unused_ok = ^{S_AXI_INTR_AWPROT, S_AXI_INTR_ARPROT,
                         S_AXI_INTR_AWADDR[1:0], S_AXI_INTR_ARADDR[1:0]};

  genvar gi;
  // Byte enables expanded to a bit mask.
  for (gi = 0; gi < DW/8; gi++) begin : g_strb
    assign w_wmask[gi*8 +: 8] = {8{S_AXI_INTR_WSTRB[gi]}};
  end

  // Per-source set condition; sources beyond C_NUM_OF_INTR never set.
  for (gi = 0; gi < DW; gi++) begin : g_detect
    if (gi < C_NUM_OF_INTR) begin : g_src
      assign w_set[gi] = (intr_src[gi] == C_INTR_ACTIVE_STATE[gi]) &&
                         (!C_INTR_SENSITIVITY[gi] || (r_prev[gi] != intr_src[gi]));
    end else begin : g_none
      assign w_set[gi] = 1'b0;
    end
  end

  assign w_clr = (w_wr_hs && (w_wsel == 3'd3)) ? (S_AXI_INTR_WDATA & w_wmask) : '0;

  // Write channel state register.
  always_ff @(posedge S_AXI_INTR_ACLK) begin
    if (S_AXI_INTR_ARESET) r_wstate <= W_IDLE;
    else                   r_wstate <= w_wstate_nxt;
  end

  // Write channel: accept AW and W only together, then hold BVALID until BREADY.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_hs      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (!S_AXI_INTR_ARESET && S_AXI_INTR_AWVALID && S_AXI_INTR_WVALID) begin
          w_wr_hs      = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: if (S_AXI_INTR_BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read channel state register.
  always_ff @(posedge S_AXI_INTR_ACLK) begin
    if (S_AXI_INTR_ARESET) r_rstate <= R_IDLE;
    else                   r_rstate <= w_rstate_nxt;
  end

  // Read channel: one-cycle ARREADY, then hold RVALID until RREADY.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (!S_AXI_INTR_ARESET && S_AXI_INTR_ARVALID) begin
          w_rd_hs      = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: if (S_AXI_INTR_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read mux over current register state (pre-write values on a shared edge).
  always_comb begin
    w_rd_mux = '0;
    case (w_rsel)
      3'd0:    w_rd_mux[0] = r_gier;
      3'd1:    w_rd_mux    = r_ier;
      3'd2:    w_rd_mux    = r_isr;
      3'd4:    w_rd_mux    = r_isr & r_ier;
      default: w_rd_mux    = '0;
    endcase
  end

  // Read data captured at the address handshake and held while RVALID.
  always_ff @(posedge S_AXI_INTR_ACLK) begin
    if (S_AXI_INTR_ARESET) r_rdata <= '0;
    else if (w_rd_hs)      r_rdata <= w_rd_mux;
  end

  // Control registers, status latch with set-over-clear, edge history.
  always_ff @(posedge S_AXI_INTR_ACLK) begin
    if (S_AXI_INTR_ARESET) begin
      r_gier <= 1'b0;
      r_ier  <= '0;
      r_isr  <= '0;
      r_prev <= '0;
    end else begin
      r_prev <= intr_src;
      r_isr  <= ((r_isr & ~w_clr) | w_set) & c_intr_mask;
      if (w_wr_hs && (w_wsel == 3'd0) && S_AXI_INTR_WSTRB[0])
        r_gier <= S_AXI_INTR_WDATA[0];
      if (w_wr_hs && (w_wsel == 3'd1))
        r_ier <= ((r_ier & ~w_wmask) | (S_AXI_INTR_WDATA & w_wmask)) & c_intr_mask;
    end
  end

  // Registered irq follows GIER & any pending bit one cycle later.
  always_ff @(posedge S_AXI_INTR_ACLK) begin
    if (S_AXI_INTR_ARESET)                r_irq <= ~C_IRQ_ACTIVE_STATE;
    else if (r_gier && |(r_isr & r_ier))  r_irq <= C_IRQ_ACTIVE_STATE;
    else                                  r_irq <= ~C_IRQ_ACTIVE_STATE;
  end

  assign S_AXI_INTR_AWREADY = w_wr_hs;
  assign S_AXI_INTR_WREADY  = w_wr_hs;
  assign S_AXI_INTR_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_INTR_BRESP   = 2'b00;
  assign S_AXI_INTR_ARREADY = w_rd_hs;
  assign S_AXI_INTR_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_INTR_RDATA   = r_rdata;
  assign S_AXI_INTR_RRESP   = 2'b00;
  assign irq                = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_tester_intr_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tester_intr_axil_slave
//  Brief    : Bench for tester_intr_axil_slave: register vectors, directed
//             interrupt/handshake sequences and randomized traffic against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tester_intr_axil_slave;

  localparam int          N    = 4;
  // bit0 rising edge, bit1 low level, bit2 falling edge, bit3 high level
  localparam logic [31:0] SENS = 32'hFFFF_FFF5;
  localparam logic [31:0] ACT  = 32'hFFFF_FFF9;
  localparam logic [31:0] MASK = (32'd1 << N) - 32'd1;
  localparam logic [3:0]  IDLE_SRC = 4'b0110;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [N-1:0] intr_src;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  tester_intr_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .C_NUM_OF_INTR(N),
    .C_INTR_SENSITIVITY(SENS), .C_INTR_ACTIVE_STATE(ACT), .C_IRQ_ACTIVE_STATE(1'b1)
  ) dut (
    .S_AXI_INTR_ACLK(clk), .S_AXI_INTR_ARESET(rst),
    .S_AXI_INTR_AWADDR(awaddr), .S_AXI_INTR_AWPROT(awprot),
    .S_AXI_INTR_AWVALID(awvalid), .S_AXI_INTR_AWREADY(awready),
    .S_AXI_INTR_WDATA(wdata), .S_AXI_INTR_WSTRB(wstrb),
    .S_AXI_INTR_WVALID(wvalid), .S_AXI_INTR_WREADY(wready),
    .S_AXI_INTR_BRESP(bresp), .S_AXI_INTR_BVALID(bvalid), .S_AXI_INTR_BREADY(bready),
    .S_AXI_INTR_ARADDR(araddr), .S_AXI_INTR_ARPROT(arprot),
    .S_AXI_INTR_ARVALID(arvalid), .S_AXI_INTR_ARREADY(arready),
    .S_AXI_INTR_RDATA(rdata), .S_AXI_INTR_RRESP(rresp),
    .S_AXI_INTR_RVALID(rvalid), .S_AXI_INTR_RREADY(rready),
    .intr_src(intr_src), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_gier, m_bpend, m_rpend, m_irq;
  logic [31:0] m_ier, m_isr, m_rdata;
  logic [N-1:0] m_prev;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a >> 2)
      0:       return {31'd0, m_gier};
      1:       return m_ier;
      2:       return m_isr;
      4:       return m_isr & m_ier;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : p_model
    logic        wr_hs, rd_hs, active;
    logic [31:0] bm, setm, clrm;
    if (rst) begin
      m_gier <= 1'b0; m_ier <= 0; m_isr <= 0; m_prev <= 0;
      m_bpend <= 1'b0; m_rpend <= 1'b0; m_rdata <= 0; m_irq <= 1'b0;
    end else begin
      wr_hs = !m_bpend && awvalid && wvalid;
      rd_hs = !m_rpend && arvalid;
      bm    = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
      setm  = 0;
      for (int i = 0; i < N; i++) begin
        active = (intr_src[i] == ACT[i]);
        if (active && (SENS[i] == 1'b0 || m_prev[i] != intr_src[i])) setm[i] = 1'b1;
      end
      clrm = (wr_hs && (awaddr >> 2) == 3) ? (wdata & bm) : 32'd0;
      m_irq  <= m_gier && ((m_isr & m_ier) != 0);
      m_isr  <= ((m_isr & ~clrm) | setm) & MASK;
      m_prev <= intr_src;
      if (wr_hs && (awaddr >> 2) == 0 && wstrb[0]) m_gier <= wdata[0];
      if (wr_hs && (awaddr >> 2) == 1) m_ier <= ((m_ier & ~bm) | (wdata & bm)) & MASK;
      if (rd_hs) begin m_rdata <= model_read(araddr); m_rpend <= 1'b1; end
      else if (m_rpend && rready) m_rpend <= 1'b0;
      if (wr_hs) m_bpend <= 1'b1;
      else if (m_bpend && bready) m_bpend <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_awready", awready, !rst && !m_bpend && awvalid && wvalid);
      chk("mon_wready",  wready,  !rst && !m_bpend && awvalid && wvalid);
      chk("mon_bvalid",  bvalid,  m_bpend);
      chk("mon_arready", arready, !rst && !m_rpend && arvalid);
      chk("mon_rvalid",  rvalid,  m_rpend);
      if (m_rpend) chk("mon_rdata", rdata, m_rdata);
      chk("mon_resp", {bresp, rresp}, 0);
      chk("mon_irq", irq, m_irq);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    while (!awready && n < 20) begin step(); @(negedge clk); n++; end
    chk("wr_accept", awready & wready, 1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("wr_bvalid", bvalid, 1);
    chk("wr_bresp", bresp, 0);
    step();
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    while (!arready && n < 20) begin step(); @(negedge clk); n++; end
    chk("rd_accept", arready, 1);
    step();
    arvalid = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", rvalid, 1);
    chk("rd_rresp", rresp, 0);
    d = rdata;
    step();
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(name, d, exp);
  endtask

  task automatic pulse_src0();
    intr_src = IDLE_SRC | 4'b0001; step();
    intr_src = IDLE_SRC;
  endtask

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    vecs[0] = '{5'h04, 32'hFFFF_FFFF, 4'hF, 5'h04, 32'h0000_000F};
    vecs[1] = '{5'h04, 32'h0000_0000, 4'h0, 5'h04, 32'h0000_000F};
    vecs[2] = '{5'h04, 32'h0000_0000, 4'h2, 5'h04, 32'h0000_000F};
    vecs[3] = '{5'h04, 32'h0000_0005, 4'h1, 5'h04, 32'h0000_0005};
    vecs[4] = '{5'h00, 32'hFFFF_FFFF, 4'hF, 5'h00, 32'h0000_0001};
    vecs[5] = '{5'h00, 32'h0000_0000, 4'hE, 5'h00, 32'h0000_0001};
    vecs[6] = '{5'h14, 32'hFFFF_FFFF, 4'hF, 5'h14, 32'h0000_0000};
    vecs[7] = '{5'h1C, 32'hFFFF_FFFF, 4'hF, 5'h04, 32'h0000_0005};
    vecs[8] = '{5'h0C, 32'hFFFF_FFFF, 4'hF, 5'h0C, 32'h0000_0000};
    vecs[9] = '{5'h00, 32'h0000_0000, 4'h1, 5'h00, 32'h0000_0000};

    rst = 1'b1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = 0; wstrb = 0; intr_src = IDLE_SRC;

    // Reset held 20 cycles
    repeat (2) step();
    mon_on = 1'b1;
    repeat (18) step();
    @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid}, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    step();
    read_chk("rst_gier", 5'h00, 0);
    read_chk("rst_ier",  5'h04, 0);
    read_chk("rst_isr",  5'h08, 0);
    read_chk("rst_ipr",  5'h10, 0);

    // Register access vectors
    for (int i = 0; i < 10; i++) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
      read_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Enables
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h1, 4'hF);
    read_chk("en_gier", 5'h00, 32'h1);
    read_chk("en_ier",  5'h04, 32'h1);

    // Edge interrupt on source 0
    pulse_src0();
    @(negedge clk); chk("edge_irq_early", irq, 0);
    step();
    @(negedge clk); chk("edge_irq", irq, 1);
    read_chk("edge_isr", 5'h08, 32'h1);
    read_chk("edge_ipr", 5'h10, 32'h1);
    axi_write(5'h0C, 32'h1, 4'hF);
    @(negedge clk); chk("ack_irq", irq, 0);
    read_chk("ack_ipr", 5'h10, 32'h0);

    // Level collision on source 3
    axi_write(5'h04, 32'h9, 4'hF);
    intr_src = IDLE_SRC | 4'b1000; step(); step();
    read_chk("lvl_isr", 5'h08, 32'h8);
    axi_write(5'h0C, 32'h8, 4'hF);
    read_chk("lvl_isr_after_ack", 5'h08, 32'h8);
    @(negedge clk); chk("lvl_irq_held", irq, 1);
    intr_src = IDLE_SRC; step();
    axi_write(5'h0C, 32'h8, 4'hF);
    read_chk("lvl_isr_cleared", 5'h08, 32'h0);
    @(negedge clk); chk("lvl_irq_off", irq, 0);

    // Masking by IER
    axi_write(5'h04, 32'h0, 4'hF);
    pulse_src0(); step(); step();
    read_chk("mask_isr", 5'h08, 32'h1);
    read_chk("mask_ipr", 5'h10, 32'h0);
    @(negedge clk); chk("mask_irq", irq, 0);
    axi_write(5'h04, 32'h1, 4'hF);
    @(negedge clk); chk("unmask_irq", irq, 1);
    axi_write(5'h0C, 32'h1, 4'hF);

    // AW ahead of W, then BREADY back-pressure
    awaddr = 5'h04; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    repeat (3) begin @(negedge clk); chk("aw_alone", awready | wready, 0); step(); end
    wvalid = 1'b1;
    @(negedge clk); chk("aw_w_accept", awready & wready, 1);
    step();
    wdata = 32'h3;
    repeat (5) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      chk("no_second_accept", awready, 0);
      step();
    end
    bready = 1'b1;
    @(negedge clk); chk("bvalid_last", bvalid, 1);
    step();
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin step(); @(negedge clk); n++; end
    chk("second_accept", awready, 1);
    step(); awvalid = 1'b0; wvalid = 1'b0;
    step();
    read_chk("second_ier", 5'h04, 32'h3);

    // RREADY back-pressure with a concurrent write to the same register
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin step(); @(negedge clk); n++; end
    awaddr = 5'h04; wdata = 32'hC; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step(); arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rdata_stable_valid", rvalid, 1);
      chk("rdata_stable", rdata, 32'h3);
      step();
      awvalid = 1'b0; wvalid = 1'b0;
    end
    rready = 1'b1;
    @(negedge clk); chk("rvalid_last", rvalid, 1);
    step();
    @(negedge clk); chk("rvalid_drop", rvalid, 0);
    read_chk("conc_ier", 5'h04, 32'hC);

    // Randomized traffic checked by the model
    for (int c = 0; c < 800; c++) begin
      intr_src = N'($urandom);
      awaddr   = 5'($urandom_range(0, 7) << 2);
      araddr   = 5'($urandom_range(0, 7) << 2);
      wdata    = $urandom;
      wstrb    = 4'($urandom);
      awvalid  = 1'($urandom); wvalid = 1'($urandom); bready = 1'($urandom);
      arvalid  = 1'($urandom); rready = 1'($urandom);
      step();
    end

    // Reset in the middle of a transaction
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    step();
    rst = 1'b1; step();
    @(negedge clk); chk("midrst_valid", {bvalid, rvalid, irq}, 0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    rst = 1'b0; intr_src = IDLE_SRC;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tester_intr_axil_slave.md
Name: tester_intr_axil_slave

Overview:
AXI4-Lite slave interrupt controller for the TesterHW IP; it is the responder that the bench's AXI master drives on the S_AXI_INTR port. It latches up to C_NUM_OF_INTR interrupt sources and exposes them through five 32-bit registers: global enable, interrupt enable, status, acknowledge and pending. It drives a single level irq line to the processing system. The register map sits at base + 0x00..0x1C.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, byte address width; register select = AWADDR/ARADDR[4:2]
C_NUM_OF_INTR, 1, number of interrupt sources (1..32)
C_INTR_SENSITIVITY, 32'hFFFFFFFF, per source: 1 = edge, 0 = level
C_INTR_ACTIVE_STATE, 32'hFFFFFFFF, per source: 1 = rising/high, 0 = falling/low
C_IRQ_ACTIVE_STATE, 1, polarity of irq when asserted

Ports:
S_AXI_INTR_ACLK  in  1  clock
S_AXI_INTR_ARESET  in  1  synchronous reset, active-high
S_AXI_INTR_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_INTR_AWPROT  in  3  ignored
S_AXI_INTR_AWVALID / AWREADY  in/out  1  write address handshake
S_AXI_INTR_WDATA  in  32  write data
S_AXI_INTR_WSTRB  in  4  byte enables
S_AXI_INTR_WVALID / WREADY  in/out  1  write data handshake
S_AXI_INTR_BRESP  out  2  always 2'b00
S_AXI_INTR_BVALID / BREADY  out/in  1  write response handshake
S_AXI_INTR_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_INTR_ARPROT  in  3  ignored
S_AXI_INTR_ARVALID / ARREADY  in/out  1  read address handshake
S_AXI_INTR_RDATA  out  32  read data
S_AXI_INTR_RRESP  out  2  always 2'b00
S_AXI_INTR_RVALID / RREADY  out/in  1  read data handshake
intr_src  in  C_NUM_OF_INTR  interrupt sources, synchronous to ACLK
irq  out  1  interrupt output

Behaviour:
- Reset: all READY/VALID outputs 0; RDATA 0; GIER, IER, ISR and the edge history registers 0; irq = ~C_IRQ_ACTIVE_STATE.
- Register map (word index = addr[4:2]):
  - 0 GIER: bit0 RW, other bits read 0.
  - 1 IER: RW, bits [N-1:0].
  - 2 ISR: RO, latched status.
  - 3 IAR: WO, write-1-to-clear ISR, reads 0.
  - 4 IPR: RO, ISR & IER.
  - 5-7: read 0, writes ignored.
  - Responses are always OKAY.
- Write FSM (W_IDLE, W_RESP):
  - In W_IDLE, AWREADY and WREADY pulse high together for exactly one cycle once AWVALID and WVALID are both high. The register updates on that same edge, honouring WSTRB per byte.
  - Next cycle: BVALID = 1, state W_RESP. BVALID holds until BREADY, then returns to W_IDLE.
  - AW alone or W alone is never accepted.
  - A new write is accepted no earlier than the cycle after BVALID falls.
- Read FSM (R_IDLE, R_DATA):
  - In R_IDLE with ARVALID, ARREADY pulses for one cycle and the address is latched.
  - Next cycle: RVALID = 1 with RDATA sampled from register state at the handshake edge. Write and read at the same edge return the old value.
  - RDATA and RVALID hold stable until RREADY, then return to R_IDLE.
  - Read and write paths are fully independent and may complete concurrently.
- Detection, per bit i:
  - Edge mode: ISR[i] is set when the registered previous value differs from intr_src[i] and intr_src[i] == ACTIVE[i].
  - Level mode: ISR[i] is set every cycle intr_src[i] == ACTIVE[i].
  - IER does not gate ISR setting; it gates IPR only.
- Set/clear collision: set and IAR clear on the same bit in the same cycle -> set wins, ISR stays 1. A level source still active re-sets ISR the cycle after clear.
- irq: registered. Asserted (= C_IRQ_ACTIVE_STATE) the cycle after GIER[0] & |IPR becomes true; deasserted the cycle after it becomes false.
- Reset mid-transaction: FSMs return to idle and all VALIDs drop the same edge; the in-flight response is lost.

Test Plan:
- Reset check: hold reset 20 cycles -> all READY/VALID = 0, irq = 0, reads of 0x00/0x04/0x08/0x10 return 0.
- Enable writes: write 0x1 to 0x00 and 0x1 to 0x04, BREADY held high -> BVALID 1 cycle after AW/W handshake, BRESP = 0. Read back 0x00 = 0x1 and 0x04 = 0x1.
- Edge interrupt: pulse intr_src[0] 0->1 for one cycle with enables set -> ISR = 0x1, IPR = 0x1, irq = 1 two cycles after the edge. Write 0x1 to 0x0C -> IPR reads 0, irq = 0 one cycle later.
- Level collision: level source held high, write IAR = 1 -> ISR reads 1 afterwards and irq stays asserted. Drop the source, then write IAR -> ISR = 0.
- Handshake stress:
  - AWVALID raised 3 cycles before WVALID -> no AWREADY until WVALID is high.
  - BREADY low for 5 cycles -> BVALID held, second write not accepted.
  - RREADY low for 4 cycles -> RDATA stable.
- Masking: IER = 0, source fires -> ISR = 1, IPR = 0, irq inactive. Then write IER = 1 -> irq asserts the next cycle.
